// File: rtl/tia_biphase_pkg.sv
// rtl/tia_biphase_pkg.sv - shared types and constants for the biphase decoder
//
// Purpose: FSM state encoding and default horizontal counter modulus shared by
//          tia_biphase_decoder and tia_hsync_counter.
// Ports:   none (package).

package tia_biphase_pkg;

  localparam int unsigned HCNT_MOD_DEFAULT = 57;
  localparam int unsigned HCNT_W           = 6;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_P1   = 3'd1,
    ST_Z1   = 3'd2,
    ST_P2   = 3'd3,
    ST_Z2   = 3'd4
  } bp_state_e;

endpackage

// File: rtl/tia_hsync_counter.sv
// rtl/tia_hsync_counter.sv - horizontal counter advanced once per biphase cycle
//
// Purpose: modulo-HCNT_MOD counter with a one-cycle wrap strobe.
// Ports:   clk   - system clock
//          rl    - asynchronous active-low reset
//          adv   - advance request (one per completed biphase cycle)
//          hcnt  - current count, 0..HCNT_MOD-1
//          hwrap - high for the cycle in which hcnt has just wrapped to 0

module tia_hsync_counter
  import tia_biphase_pkg::*;
#(
  parameter int unsigned HCNT_MOD = HCNT_MOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rl,
  input  logic              adv,
  output logic [HCNT_W-1:0] hcnt,
  output logic              hwrap
);

  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HCNT_MOD - 1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              hwrap_q, hwrap_d;

  always_comb begin
    hcnt_d  = hcnt_q;
    hwrap_d = 1'b0;
    if (adv) begin
      if (hcnt_q == HCNT_LAST) begin
        hcnt_d  = '0;
        hwrap_d = 1'b1;
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      hcnt_q  <= '0;
      hwrap_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      hwrap_q <= hwrap_d;
    end
  end

  assign hcnt  = hcnt_q;
  assign hwrap = hwrap_q;

endmodule

// File: rtl/tia_biphase_decoder.sv
// rtl/tia_biphase_decoder.sv - biphase clock phase tracker and horizontal counter
//
// Purpose: registers phi1/phi2, tracks the P1 -> Z1 -> P2 -> Z2 sequence, emits
//          a one-cycle strobe on each phase entry, reports lock and counts
//          complete biphase cycles. Any illegal sample drops back to HUNT.
// Ports:   clk      - system clock
//          rl       - asynchronous active-low reset
//          phi1     - biphase phase 1 (synchronous to clk)
//          phi2     - biphase phase 2 (synchronous to clk)
//          p1_pulse - strobe on entry to P1
//          p2_pulse - strobe on entry to P2
//          lock     - sequence tracked legally since the last Z2 -> P1
//          hcnt     - horizontal count
//          hwrap    - strobe when hcnt wraps to 0
//          err      - sticky violation flag
// Build option: TIA_BIPHASE_DECODER_ERR_EN enables the sticky err flag;
//               without it err is tied to 0.

module tia_biphase_decoder
  import tia_biphase_pkg::*;
#(
  parameter int unsigned HCNT_MOD = HCNT_MOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rl,
  input  logic              phi1,
  input  logic              phi2,
  output logic              p1_pulse,
  output logic              p2_pulse,
  output logic              lock,
  output logic [HCNT_W-1:0] hcnt,
  output logic              hwrap,
  output logic              err
);

  bp_state_e state_q, state_d;
  logic      p1_q, p2_q;
  logic      violation;
  logic      adv;
  logic      lock_q, lock_d;
  logic      p1_pulse_q, p1_pulse_d;
  logic      p2_pulse_q, p2_pulse_d;

  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    violation = 1'b0;
    // Overlap of both phases is illegal everywhere and wins over any transition.
    if (p1_q && p2_q) begin
      violation = 1'b1;
    end else begin
      unique case (state_q)
        ST_HUNT: if (p1_q) state_d = ST_P1;
        ST_P1: begin
          if (p2_q)       violation = 1'b1;
          else if (!p1_q) state_d   = ST_Z1;
        end
        ST_Z1: begin
          if (p1_q)      violation = 1'b1;
          else if (p2_q) state_d   = ST_P2;
        end
        ST_P2: begin
          if (p1_q)       violation = 1'b1;
          else if (!p2_q) state_d   = ST_Z2;
        end
        ST_Z2: begin
          if (p2_q)      violation = 1'b1;
          else if (p1_q) state_d   = ST_P1;
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (violation) state_d = ST_HUNT;

    // Only a Z2 -> P1 step completes a cycle; entry from HUNT neither counts nor locks.
    adv        = (state_q == ST_Z2) && (state_d == ST_P1);
    lock_d     = violation ? 1'b0 : (adv ? 1'b1 : lock_q);
    p1_pulse_d = (state_d == ST_P1) && (state_q != ST_P1);
    p2_pulse_d = (state_d == ST_P2) && (state_q != ST_P2);
  end

  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      lock_q     <= 1'b0;
      p1_pulse_q <= 1'b0;
      p2_pulse_q <= 1'b0;
    end else begin
      p1_q       <= phi1;
      p2_q       <= phi2;
      lock_q     <= lock_d;
      p1_pulse_q <= p1_pulse_d;
      p2_pulse_q <= p2_pulse_d;
    end
  end

`ifdef TIA_BIPHASE_DECODER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | violation;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  tia_hsync_counter #(
    .HCNT_MOD (HCNT_MOD)
  ) u_hsync_counter (
    .clk   (clk),
    .rl    (rl),
    .adv   (adv),
    .hcnt  (hcnt),
    .hwrap (hwrap)
  );

  assign p1_pulse = p1_pulse_q;
  assign p2_pulse = p2_pulse_q;
  assign lock     = lock_q;

endmodule

// File: tb/tb_tia_biphase_decoder.sv
// tb/tb_tia_biphase_decoder.sv - scoreboard bench for tia_biphase_decoder

module tb_tia_biphase_decoder;

`ifdef TIA_BIPHASE_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       is_p2;
    logic       lock;
    logic [5:0] hcnt;
    logic       hwrap;
  } exp_t;

  logic       clk;
  logic       rl;
  logic       phi1;
  logic       phi2;
  logic       p1_pulse;
  logic       p2_pulse;
  logic       lock;
  logic [5:0] hcnt;
  logic       hwrap;
  logic       err;

  exp_t sb_q[$];
  int   n_run;
  int   n_fail;
  int   hwrap_seen;
  logic exp_err;

  tia_biphase_decoder #(.HCNT_MOD(57)) dut (
    .clk      (clk),
    .rl       (rl),
    .phi1     (phi1),
    .phi2     (phi2),
    .p1_pulse (p1_pulse),
    .p2_pulse (p2_pulse),
    .lock     (lock),
    .hcnt     (hcnt),
    .hwrap    (hwrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one clock cycle of phase inputs; returns at the following negedge.
  task automatic cyc(input logic a, input logic b);
    phi1 = a;
    phi2 = b;
    @(negedge clk);
  endtask

  task automatic push(input logic is_p2, input logic lk, input int hc, input logic wr);
    exp_t e;
    e.is_p2 = is_p2;
    e.lock  = lk;
    e.hcnt  = 6'(hc);
    e.hwrap = wr;
    sb_q.push_back(e);
  endtask

  // One full biphase cycle with each phase/gap held n clocks.
  task automatic bp_cycle(input logic lk, input int hc, input logic wr, input int n);
    push(1'b0, lk, hc, wr);
    repeat (n) cyc(1'b1, 1'b0);
    repeat (n) cyc(1'b0, 1'b0);
    push(1'b1, lk, hc, 1'b0);
    repeat (n) cyc(1'b0, 1'b1);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  initial begin
    n_run      = 0;
    n_fail     = 0;
    hwrap_seen = 0;
    exp_err    = 1'b0;
    rl         = 1'b0;
    phi1       = 1'b0;
    phi2       = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rl && (p1_pulse || p2_pulse || hwrap)) begin
          exp_t act;
          exp_t e;
          act.is_p2 = p2_pulse;
          act.lock  = lock;
          act.hcnt  = hcnt;
          act.hwrap = hwrap;
          if (hwrap) hwrap_seen++;
          n_run++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: p1=%0b p2=%0b lock=%0b hcnt=%0d hwrap=%0b, none expected",
                     p1_pulse, p2_pulse, lock, hcnt, hwrap);
          end else begin
            e = sb_q.pop_front();
            if (act !== e || (p1_pulse && p2_pulse)) begin
              n_fail++;
              $display("FAIL pulse_event: got p2=%0b lock=%0b hcnt=%0d hwrap=%0b (p1=%0b) expected p2=%0b lock=%0b hcnt=%0d hwrap=%0b",
                       act.is_p2, act.lock, act.hcnt, act.hwrap, p1_pulse,
                       e.is_p2, e.lock, e.hcnt, e.hwrap);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_hcnt", 32'(hcnt), 32'd0);
    chk("rst_hwrap", 32'(hwrap), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pulses", 32'({p1_pulse, p2_pulse}), 32'd0);
    rl = 1'b1;
    cyc(1'b0, 1'b0);

    // First cycle from HUNT: pulse two edges after phi1 is first sampled
    push(1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("p1_latency_edge1", 32'(p1_pulse), 32'd0);
    cyc(1'b0, 1'b0);
    chk("p1_latency_edge2", 32'(p1_pulse), 32'd1);
    push(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("p2_latency_edge1", 32'(p2_pulse), 32'd0);
    cyc(1'b0, 1'b0);
    chk("p2_latency_edge2", 32'(p2_pulse), 32'd1);
    bp_cycle(1'b1, 1, 1'b0, 1);
    chk("lock_after_first_cycle", 32'(lock), 32'd1);
    chk("hcnt_after_first_cycle", 32'(hcnt), 32'd1);

    // 57 cycles: hcnt 2..56, wraps to 0, then 1
    for (int i = 2; i <= 58; i++) bp_cycle(1'b1, i % 57, (i == 57), 1);
    chk("hwrap_count", 32'(hwrap_seen), 32'd1);
    chk("hcnt_after_wrap", 32'(hcnt), 32'd1);

    // Overlap while locked (state P2 -> Z2 on this edge, overlap sampled)
    cyc(1'b1, 1'b1);
    chk("lock_before_overlap", 32'(lock), 32'd1);
    cyc(1'b0, 1'b0);
    exp_err = ERR_EN;
    chk("overlap_lock", 32'(lock), 32'd0);
    chk("overlap_hcnt", 32'(hcnt), 32'd1);
    chk("overlap_err", 32'(err), 32'(exp_err));
    bp_cycle(1'b0, 1, 1'b0, 1);
    bp_cycle(1'b1, 2, 1'b0, 1);
    chk("relock_after_overlap", 32'(lock), 32'd1);

    // Phase repeat: phi1 again while in Z1
    push(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("repeat_lock", 32'(lock), 32'd0);
    chk("repeat_no_pulse", 32'(p1_pulse), 32'd0);
    chk("repeat_hcnt", 32'(hcnt), 32'd3);
    chk("repeat_err", 32'(err), 32'(exp_err));
    cyc(1'b0, 1'b0);
    bp_cycle(1'b0, 3, 1'b0, 1);
    bp_cycle(1'b1, 4, 1'b0, 1);
    chk("relock_after_repeat", 32'(lock), 32'd1);

    // Stretched phases, 3 clocks each
    for (int i = 5; i <= 7; i++) bp_cycle(1'b1, i, 1'b0, 3);
    chk("stretch_lock", 32'(lock), 32'd1);
    chk("stretch_hcnt", 32'(hcnt), 32'd7);
    bp_cycle(1'b1, 8, 1'b0, 1);
    bp_cycle(1'b1, 9, 1'b0, 1);

    // Async reset mid-P2 with hcnt=10
    push(1'b0, 1'b1, 10, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    push(1'b1, 1'b1, 10, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("mid_p2_hcnt", 32'(hcnt), 32'd10);
    #2 rl = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("async_rst_hcnt", 32'(hcnt), 32'd0);
    chk("async_rst_lock", 32'(lock), 32'd0);
    chk("async_rst_pulses", 32'({p1_pulse, p2_pulse}), 32'd0);
    chk("async_rst_hwrap", 32'(hwrap), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);

    // Release mid-sequence: resume in HUNT, first phi1 does not count
    @(negedge clk);
    rl = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    bp_cycle(1'b0, 0, 1'b0, 1);
    chk("resume_hcnt_no_inc", 32'(hcnt), 32'd0);
    bp_cycle(1'b1, 1, 1'b0, 1);
    chk("resume_lock", 32'(lock), 32'd1);
    chk("resume_hcnt", 32'(hcnt), 32'd1);
    chk("resume_err", 32'(err), 32'(exp_err));

    repeat (4) cyc(1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("hwrap_total", 32'(hwrap_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/tia_biphase_decoder.md
TIA_BIPHASE_DECODER -- requirements
Module: tia_biphase_decoder

Interface
REQ-001 Parameter: HCNT_MOD, default 57, horizontal counter modulus (states 0..HCNT_MOD-1); legal range 2..64.
REQ-002 clk  input  1  Single system clock; all state changes on rising edge.
REQ-003 rl  input  1  Asynchronous, active-low reset.
REQ-004 phi1  input  1  Biphase clock phase 1 from the biphase clock generator, synchronous to clk.
REQ-005 phi2  input  1  Biphase clock phase 2 from the biphase clock generator, synchronous to clk.
REQ-006 p1_pulse  output  1  One-cycle strobe on each accepted phi1 phase entry.
REQ-007 p2_pulse  output  1  One-cycle strobe on each accepted phi2 phase entry.
REQ-008 lock  output  1  High while the phi1/phi2 sequence is being tracked legally.
REQ-009 hcnt  output  6  Horizontal count, advanced once per full biphase cycle.
REQ-010 hwrap  output  1  One-cycle strobe when hcnt wraps from HCNT_MOD-1 to 0.
REQ-011 err  output  1  Sticky protocol-error flag (see Configuration).

Function
REQ-012 Input stage: phi1/phi2 SHALL be registered once (p1_q, p2_q) every clk rising edge; the FSM acts only on p1_q/p2_q.
REQ-013 FSM states: HUNT, P1, Z1, P2, Z2; legal sequence P1 -> Z1 -> P2 -> Z2 -> P1.
REQ-014 HUNT: stays until p1_q=1 and p2_q=0, then -> P1; lock stays 0.
REQ-015 P1: p1_q=1,p2_q=0 stay; both 0 -> Z1; p2_q=1 -> violation.
REQ-016 Z1: both 0 stay; p2_q=1 -> P2; p1_q=1 -> violation.
REQ-017 P2: p2_q=1,p1_q=0 stay; both 0 -> Z2; p1_q=1 -> violation.
REQ-018 Z2: both 0 stay; p1_q=1 -> P1; p2_q=1 -> violation.
REQ-019 p1_q=p2_q=1 in any state SHALL be a violation (overlap), overriding all other transitions.
REQ-020 Violation: FSM -> HUNT, lock -> 0 on the same edge; no pulse issued on that edge.
REQ-021 p1_pulse/p2_pulse SHALL be asserted for exactly the one cycle following the edge that enters P1/P2; latency from first phi sample high to pulse high = 2 clk edges.
REQ-022 lock SHALL rise on the edge entering P1 from Z2 (first complete cycle) and stay high until violation or reset.
REQ-023 hcnt SHALL increment on each Z2 -> P1 transition; at HCNT_MOD-1 it SHALL load 0 and assert hwrap for that one cycle; entry from HUNT does not increment.
REQ-024 hcnt SHALL hold its value through violations and HUNT.

Reset
REQ-025 rl=0 SHALL asynchronously force: FSM=HUNT, p1_q=p2_q=0, p1_pulse=p2_pulse=0, lock=0, hcnt=0, hwrap=0, err=0.
REQ-026 Reset deassertion mid-sequence SHALL resume in HUNT; the first phi1 sample after release enters P1 without incrementing hcnt.

Configuration
REQ-027 Macro TIA_BIPHASE_DECODER_ERR_EN defined: err SHALL set on the edge of any violation and remain 1 until rl=0.
REQ-028 Macro undefined: err SHALL be constant 0 and no error-flag storage synthesized; FSM violation recovery (REQ-020) is unchanged.

Structure
REQ-029 Shared package tia_biphase_pkg SHALL hold the FSM state typedef/encoding and the default HCNT_MOD constant.
REQ-030 hcnt/hwrap logic SHALL be a sub-module tia_hsync_counter (inputs clk, rl, adv; outputs hcnt, hwrap).

Verification
REQ-031 Reset, then drive generator-legal sequence phi1,Z,phi2,Z,phi1 (one clk each) -> p1_pulse at edge 2, p2_pulse 2 edges after phi2, lock=1 after second phi1, hcnt=1.
REQ-032 Run 57 full biphase cycles after lock -> hcnt 0..56 then 0, hwrap high exactly once, coincident with the wrap.
REQ-033 Force phi1=phi2=1 for one cycle while locked -> lock=0 next edge, FSM HUNT, err=1 (with macro) / err=0 (without), hcnt unchanged.
REQ-034 In Z1 drive phi1=1 (phase repeat) -> violation, lock=0, no p1_pulse; relock after one legal cycle.
REQ-035 Assert rl=0 mid-P2 with hcnt=10 -> all outputs 0 immediately (asynchronous, before next clk edge); err cleared.
REQ-036 Stretch each phase to 3 clk cycles -> exactly one p1_pulse and one p2_pulse per biphase cycle, lock stays 1.
